// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: MEM-stage byte-lane data RAM plus the MEM/WB register.
// Build macro MEMSTAGE_DISP_PORT_EN adds an independent display read port.
module mem_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16384,
  parameter int REG_W  = 3,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_w,
  input  logic              flush_w,
  input  logic              PCSrcM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [1:0]        SizeM,
  input  logic              SignedM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [REG_W-1:0]  WA3M,
  input  logic              disp_en,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic [DATA_W-1:0] ALUOutM,
  output logic              PCSrcW,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [REG_W-1:0]  WA3W,
  output logic              MemErrW
);

  localparam int B     = DATA_W / 8;
  localparam int OFF_W = $clog2(B);
  localparam int CNT_W = OFF_W + 2;
  localparam int SH_W  = OFF_W + 3;

  typedef struct packed {
    logic              pcsrc;
    logic              regw;
    logic              m2r;
    logic              err;
    logic              flt;
    logic              rv;
    logic              sgn;
    logic [1:0]        size;
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  wa3;
  } memwb_t;

  logic [DATA_W-1:0] widx_full;
  logic [ADDR_W-1:0] widx;
  logic [OFF_W-1:0]  off;
  logic [CNT_W-1:0]  nbytes;
  logic              fault;
  logic [B-1:0]      be;
  logic [SH_W-1:0]   wsh;
  logic [DATA_W-1:0] wdata;
  logic              wr_ok;
  logic              we;
  logic [1:0]        rsync_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  memwb_t            wb_q;
  memwb_t            wb_d;
  logic [DATA_W-1:0] rsh;
  logic [DATA_W-1:0] lmask;
  logic [DATA_W-1:0] ext;
  logic              sbit;

  assign ALUOutM   = ALUResultM;
  assign widx_full = ALUResultM / DATA_W'(B);
  assign widx      = ADDR_W'(widx_full);
  assign off       = OFF_W'(ALUResultM % DATA_W'(B));

  // Access width in bytes and range/alignment fault of the M access
  always_comb begin
    nbytes = CNT_W'(1);
    unique case (SizeM)
      2'b00: nbytes = CNT_W'(1);
      2'b01: nbytes = CNT_W'(2);
      2'b10: nbytes = CNT_W'(4);
      2'b11: nbytes = CNT_W'(B);
    endcase
    fault = 1'b0;
    if (widx_full >= DATA_W'(DEPTH))
      fault = 1'b1;
    if (SizeM == 2'b01 && off[0])
      fault = 1'b1;
    if (SizeM == 2'b10 && off[1:0] != 2'b00)
      fault = 1'b1;
    if (SizeM == 2'b11 && off != '0)
      fault = 1'b1;
    // never let an access spill into the next word
    if ((CNT_W'(off) + nbytes) > CNT_W'(B))
      fault = 1'b1;
  end

  // Byte-lane enables covering [off, off+nbytes)
  always_comb begin
    be = '0;
    for (int i = 0; i < B; i++) begin
      be[i] = (CNT_W'(i) >= CNT_W'(off)) &&
              (CNT_W'(i) < CNT_W'(off) + nbytes);
    end
  end

  assign wsh   = {off, 3'b000};
  assign wdata = WriteDataM << wsh;
  assign we    = MemWriteM & ~stall_w & ~fault & wr_ok;

  // Reset release synchroniser gating RAM writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rsync_q <= 2'b00;
    else
      rsync_q <= {rsync_q[0], 1'b1};
  end

  assign wr_ok = rsync_q[1];

  // RAM write port: only the addressed byte lanes change
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < B; i++) begin
        if (be[i])
          mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Pipeline read port, frozen while the W stage is stalled
  always_ff @(posedge clk) begin
    if (!stall_w)
      rd_q <= mem[widx];
  end

  // MEM/WB next state: capture unless stalled, flush kills control
  always_comb begin
    wb_d = wb_q;
    if (!stall_w) begin
      wb_d.pcsrc = PCSrcM;
      wb_d.regw  = RegWriteM;
      wb_d.m2r   = MemtoRegM;
      wb_d.err   = fault & (MemWriteM | MemtoRegM);
      wb_d.flt   = fault;
      wb_d.rv    = 1'b1;
      wb_d.sgn   = SignedM;
      wb_d.size  = SizeM;
      wb_d.off   = off;
      wb_d.alu   = ALUResultM;
      wb_d.wa3   = WA3M;
    end
    if (flush_w) begin
      wb_d.pcsrc = 1'b0;
      wb_d.regw  = 1'b0;
      wb_d.m2r   = 1'b0;
      wb_d.err   = 1'b0;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wb_q <= '0;
    else
      wb_q <= wb_d;
  end

  // Load lane select and zero/sign extension
  always_comb begin
    rsh   = rd_q >> {wb_q.off, 3'b000};
    lmask = '1;
    sbit  = 1'b0;
    unique case (wb_q.size)
      2'b00: begin
        lmask = DATA_W'(8'hFF);
        sbit  = rsh[7];
      end
      2'b01: begin
        lmask = DATA_W'(16'hFFFF);
        sbit  = rsh[15];
      end
      2'b10: begin
        lmask = DATA_W'(32'hFFFF_FFFF);
        sbit  = rsh[31];
      end
      2'b11: begin
        lmask = '1;
        sbit  = 1'b0;
      end
    endcase
    ext = (rsh & lmask) |
          ((wb_q.sgn & sbit) ? ~lmask : '0);
  end

  assign ReadDataW = (wb_q.rv && !wb_q.flt) ? ext : '0;
  assign PCSrcW    = wb_q.pcsrc;
  assign RegWriteW = wb_q.regw;
  assign MemtoRegW = wb_q.m2r;
  assign MemErrW   = wb_q.err;
  assign ALUOutW   = wb_q.alu;
  assign WA3W      = wb_q.wa3;

`ifdef MEMSTAGE_DISP_PORT_EN
  logic [DATA_W-1:0] disp_raw_q;
  logic              disp_seen_q;
  logic              disp_vld_q;

  // Display read port: old data on a same-cycle store
  always_ff @(posedge clk) begin
    if (disp_en)
      disp_raw_q <= mem[disp_addr];
  end

  // Display valid and post-reset output qualifier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_vld_q  <= 1'b0;
      disp_seen_q <= 1'b0;
    end else begin
      disp_vld_q  <= disp_en;
      disp_seen_q <= disp_seen_q | disp_en;
    end
  end

  assign disp_data  = disp_seen_q ? disp_raw_q : '0;
  assign disp_valid = disp_vld_q;
`else
  logic unused_disp;

  assign unused_disp = ^{disp_en, disp_addr};
  assign disp_data   = '0;
  assign disp_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: byte-model scoreboard bench for mem_stage_pipe.
// Display checks follow MEMSTAGE_DISP_PORT_EN.
module tb_mem_stage_pipe;

  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int RW    = 3;
  localparam int AW    = 8;
  localparam int B     = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall_w = 1'b0;
  logic          flush_w = 1'b0;
  logic          PCSrcM = 1'b0;
  logic          RegWriteM = 1'b0;
  logic          MemtoRegM = 1'b0;
  logic          MemWriteM = 1'b0;
  logic [1:0]    SizeM = 2'b00;
  logic          SignedM = 1'b0;
  logic [DW-1:0] ALUResultM = '0;
  logic [DW-1:0] WriteDataM = '0;
  logic [RW-1:0] WA3M = '0;
  logic          disp_en = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic [DW-1:0] ALUOutM;
  logic          PCSrcW;
  logic          RegWriteW;
  logic          MemtoRegW;
  logic [DW-1:0] ReadDataW;
  logic [DW-1:0] ALUOutW;
  logic [RW-1:0] WA3W;
  logic          MemErrW;

  mem_stage_pipe #(
    .DATA_W(DW),
    .DEPTH (DEPTH),
    .REG_W (RW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall_w   (stall_w),
    .flush_w   (flush_w),
    .PCSrcM    (PCSrcM),
    .RegWriteM (RegWriteM),
    .MemtoRegM (MemtoRegM),
    .MemWriteM (MemWriteM),
    .SizeM     (SizeM),
    .SignedM   (SignedM),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .WA3M      (WA3M),
    .disp_en   (disp_en),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .ALUOutM   (ALUOutM),
    .PCSrcW    (PCSrcW),
    .RegWriteW (RegWriteW),
    .MemtoRegW (MemtoRegW),
    .ReadDataW (ReadDataW),
    .ALUOutW   (ALUOutW),
    .WA3W      (WA3W),
    .MemErrW   (MemErrW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic          ld;
    logic [1:0]    sz;
    logic          sg;
    logic [DW-1:0] a;
    logic [DW-1:0] d;
    logic [RW-1:0] wa;
  } op_t;

  typedef struct {
    logic          pcs;
    logic          rw;
    logic          m2r;
    logic          err;
    logic [DW-1:0] alu;
    logic [RW-1:0] wa3;
    logic          chk;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t        sbq[$];
  byte unsigned mdl[int];
  int          n_run = 0;
  int          n_fail = 0;

  function automatic op_t mk(input logic wr, input logic ld,
                             input logic [1:0] sz, input logic sg,
                             input logic [DW-1:0] a,
                             input logic [DW-1:0] d,
                             input logic [RW-1:0] wa);
    op_t o;
    o.wr = wr; o.ld = ld; o.sz = sz; o.sg = sg;
    o.a = a; o.d = d; o.wa = wa;
    return o;
  endfunction

  function automatic int nb(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return B;
    endcase
  endfunction

  function automatic logic m_fault(input logic [1:0] sz,
                                   input logic [DW-1:0] a);
    int unsigned off;
    off = a % B;
    if ((a / B) >= DEPTH) return 1'b1;
    if (sz == 2'b01 && (off % 2) != 0) return 1'b1;
    if (sz == 2'b10 && (off % 4) != 0) return 1'b1;
    if (sz == 2'b11 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] m_load(input logic [1:0] sz,
                                           input logic sg,
                                           input logic [DW-1:0] a);
    logic [63:0] v;
    int          n;
    n = nb(sz);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[int'(a) + i];
    if (sg && sz != 2'b11 && v[8*n-1])
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v[DW-1:0];
  endfunction

  function automatic void m_store(input logic [1:0] sz,
                                  input logic [DW-1:0] a,
                                  input logic [DW-1:0] d);
    for (int i = 0; i < nb(sz); i++) mdl[int'(a) + i] = d[8*i +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    PCSrcM = 1'b0; RegWriteM = 1'b0; MemtoRegM = 1'b0;
    MemWriteM = 1'b0; SizeM = 2'b00; SignedM = 1'b0;
    ALUResultM = '0; WriteDataM = '0; WA3M = '0;
  endtask

  // drive one M-stage op and push what the W stage must show next edge
  task automatic issue(input op_t o);
    exp_t x;
    logic f;
    f = m_fault(o.sz, o.a);
    PCSrcM = (o.wa == 3'd7); RegWriteM = o.ld; MemtoRegM = o.ld;
    MemWriteM = o.wr; SizeM = o.sz; SignedM = o.sg;
    ALUResultM = o.a; WriteDataM = o.d; WA3M = o.wa;
    x.pcs = (o.wa == 3'd7) & ~flush_w;
    x.rw  = o.ld & ~flush_w;
    x.m2r = o.ld & ~flush_w;
    x.err = f & (o.wr | o.ld) & ~flush_w;
    x.alu = o.a;
    x.wa3 = o.wa;
    x.chk = o.ld & ~flush_w;
    x.rd  = '0;
    if (x.chk && !f) x.rd = m_load(o.sz, o.sg, o.a);
    if (o.wr && !f) m_store(o.sz, o.a, o.d);
    sbq.push_back(x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    RegWriteM = 1'b1; MemtoRegM = 1'b1; PCSrcM = 1'b1;
    ALUResultM = 32'h1234; WA3M = 3'd5; disp_en = 1'b1;
    tick(); tick();
    n_run++;
    if ({PCSrcW, RegWriteW, MemtoRegW, MemErrW, ReadDataW, ALUOutW,
         WA3W, disp_data, disp_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got alu=%h wa3=%0d rw=%b dv=%b exp all 0",
               ALUOutW, WA3W, RegWriteW, disp_valid);
    end
    rst_n = 1'b1;
    disp_en = 1'b0;
    idle();
    tick(); tick(); tick();
  endtask

  task automatic test_byte_load();
    op_t  ops[$];
    exp_t x;
    ops.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 3'd0));
    ops.push_back(mk(1'b0, 1'b1, 2'd0, 1'b1, 32'h13, 32'h0, 3'd1));
    ops.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0, 3'd2));
    ops.push_back(mk(1'b0, 1'b1, 2'd1, 1'b1, 32'h12, 32'h0, 3'd7));
    ops.push_back(mk(1'b0, 1'b1, 2'd0, 1'b1, 32'h10, 32'h0, 3'd3));
    ops.push_back(mk(1'b0, 1'b1, 2'd3, 1'b1, 32'h10, 32'h0, 3'd4));
    foreach (ops[i]) begin
      issue(ops[i]);
      #1;
      n_run++;
      if (ALUOutM !== ops[i].a) begin
        n_fail++;
        $display("FAIL byte_load aluoutm got %h exp %h", ALUOutM, ops[i].a);
      end
      tick();
      x = sbq.pop_front();
      n_run++;
      if ({PCSrcW, RegWriteW, MemtoRegW, MemErrW, ALUOutW, WA3W} !==
          {x.pcs, x.rw, x.m2r, x.err, x.alu, x.wa3}) begin
        n_fail++;
        $display("FAIL byte_load wb[%0d] got %b%b%b%b %h %0d exp %b%b%b%b %h %0d",
                 i, PCSrcW, RegWriteW, MemtoRegW, MemErrW, ALUOutW, WA3W,
                 x.pcs, x.rw, x.m2r, x.err, x.alu, x.wa3);
      end
      if (x.chk) begin
        n_run++;
        if (ReadDataW !== x.rd) begin
          n_fail++;
          $display("FAIL byte_load rdata[%0d] got %h exp %h", i, ReadDataW, x.rd);
        end
      end
    end
  endtask

  task automatic test_lanes_faults();
    op_t  ops[$];
    exp_t x;
    ops.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'hAAAAAAAA, 3'd0));
    ops.push_back(mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h1234, 3'd0));
    ops.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 3'd1));
    ops.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 32'h21, 32'hFFFFFF5A, 3'd0));
    ops.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 3'd2));
    ops.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h21, 32'h0, 3'd3));
    ops.push_back(mk(1'b0, 1'b1, 2'd1, 1'b1, 32'h23, 32'h0, 3'd3));
    ops.push_back(mk(1'b0, 1'b1, 2'd3, 1'b0, 32'h22, 32'h0, 3'd3));
    ops.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h12345678, 3'd0));
    ops.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, DEPTH * B, 32'hFFFFFFFF, 3'd0));
    ops.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h22, 32'hFFFFFFFF, 3'd0));
    ops.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0, 3'd5));
    ops.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 3'd6));
    ops.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, DEPTH * B + 4, 32'h0, 3'd6));
    foreach (ops[i]) begin
      issue(ops[i]);
      tick();
      x = sbq.pop_front();
      n_run++;
      if ({PCSrcW, RegWriteW, MemtoRegW, MemErrW, ALUOutW, WA3W} !==
          {x.pcs, x.rw, x.m2r, x.err, x.alu, x.wa3}) begin
        n_fail++;
        $display("FAIL lanes_faults wb[%0d] got %b%b%b%b %h %0d exp %b%b%b%b %h %0d",
                 i, PCSrcW, RegWriteW, MemtoRegW, MemErrW, ALUOutW, WA3W,
                 x.pcs, x.rw, x.m2r, x.err, x.alu, x.wa3);
      end
      if (x.chk) begin
        n_run++;
        if (ReadDataW !== x.rd) begin
          n_fail++;
          $display("FAIL lanes_faults rdata[%0d] got %h exp %h", i, ReadDataW, x.rd);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t           ops[$];
    exp_t          x;
    logic [DW-1:0] a;
    logic [1:0]    sz;
    int unsigned   o1;
    int unsigned   o2;
    for (int k = 0; k < 6; k++) begin
      a  = DW'($urandom_range(DEPTH - 1, 64)) << 2;
      sz = 2'($urandom_range(1, 0));
      o1 = (sz == 2'd1) ? 2 * $urandom_range(1, 0) : $urandom_range(3, 0);
      o2 = (sz == 2'd1) ? 2 * $urandom_range(1, 0) : $urandom_range(3, 0);
      ops.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, a, DW'($urandom), 3'd0));
      ops.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, a, 32'h0, 3'(k)));
      ops.push_back(mk(1'b1, 1'b0, sz, 1'b0, a + o1, DW'($urandom), 3'd0));
      ops.push_back(mk(1'b0, 1'b1, sz, 1'($urandom_range(1, 0)), a + o2,
                       32'h0, 3'(k + 1)));
    end
    foreach (ops[i]) begin
      issue(ops[i]);
      tick();
      x = sbq.pop_front();
      n_run++;
      if ({PCSrcW, RegWriteW, MemtoRegW, MemErrW, ALUOutW, WA3W} !==
          {x.pcs, x.rw, x.m2r, x.err, x.alu, x.wa3}) begin
        n_fail++;
        $display("FAIL b2b wb[%0d] got %b%b%b%b %h %0d exp %b%b%b%b %h %0d",
                 i, PCSrcW, RegWriteW, MemtoRegW, MemErrW, ALUOutW, WA3W,
                 x.pcs, x.rw, x.m2r, x.err, x.alu, x.wa3);
      end
      if (x.chk) begin
        n_run++;
        if (ReadDataW !== x.rd) begin
          n_fail++;
          $display("FAIL b2b rdata[%0d] got %h exp %h", i, ReadDataW, x.rd);
        end
      end
    end
  endtask

  task automatic test_stall_flush();
    exp_t x;
    exp_t held;
    issue(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 3'd7));
    tick();
    held = sbq.pop_front();
    n_run++;
    if ({RegWriteW, ALUOutW, ReadDataW} !== {held.rw, held.alu, held.rd}) begin
      n_fail++;
      $display("FAIL stall_pre got %b %h %h exp %b %h %h",
               RegWriteW, ALUOutW, ReadDataW, held.rw, held.alu, held.rd);
    end
    stall_w = 1'b1;
    ALUResultM = 32'h20; WA3M = 3'd2; PCSrcM = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_run++;
      if ({PCSrcW, RegWriteW, MemtoRegW, MemErrW, ALUOutW, WA3W, ReadDataW} !==
          {held.pcs, held.rw, held.m2r, held.err, held.alu, held.wa3, held.rd}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got %h %0d %h exp %h %0d %h",
                 k, ALUOutW, WA3W, ReadDataW, held.alu, held.wa3, held.rd);
      end
    end
    stall_w = 1'b0;
    issue(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 3'd2));
    tick();
    x = sbq.pop_front();
    n_run++;
    if ({RegWriteW, ALUOutW, WA3W, ReadDataW} !== {x.rw, x.alu, x.wa3, x.rd}) begin
      n_fail++;
      $display("FAIL stall_release got %b %h %0d %h exp %b %h %0d %h",
               RegWriteW, ALUOutW, WA3W, ReadDataW, x.rw, x.alu, x.wa3, x.rd);
    end
    flush_w = 1'b1;
    issue(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h77777777, 3'd7));
    tick();
    x = sbq.pop_front();
    n_run++;
    if ({PCSrcW, RegWriteW, MemtoRegW, MemErrW, ALUOutW} !==
        {x.pcs, x.rw, x.m2r, x.err, x.alu}) begin
      n_fail++;
      $display("FAIL flush got %b%b%b%b %h exp %b%b%b%b %h",
               PCSrcW, RegWriteW, MemtoRegW, MemErrW, ALUOutW,
               x.pcs, x.rw, x.m2r, x.err, x.alu);
    end
    flush_w = 1'b0;
    issue(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0, 3'd7));
    tick();
    x = sbq.pop_front();
    n_run++;
    if ({PCSrcW, RegWriteW, ReadDataW} !== {x.pcs, x.rw, x.rd}) begin
      n_fail++;
      $display("FAIL flush_store got %b %b %h exp %b %b %h",
               PCSrcW, RegWriteW, ReadDataW, x.pcs, x.rw, x.rd);
    end
    stall_w = 1'b1;
    flush_w = 1'b1;
    tick();
    n_run++;
    if ({PCSrcW, RegWriteW, MemtoRegW, MemErrW} !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_over_stall got %b%b%b%b exp 0000",
               PCSrcW, RegWriteW, MemtoRegW, MemErrW);
    end
    stall_w = 1'b0;
    flush_w = 1'b0;
    idle();
  endtask

  task automatic test_display();
    exp_t          x;
    logic [DW-1:0] old;
    old = m_load(2'd2, 1'b0, 32'h10);
    disp_en = 1'b1;
    disp_addr = AW'(4);
    issue(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h55, 3'd0));
    tick();
    x = sbq.pop_front();
    n_run++;
    if ({MemErrW, ALUOutW} !== {x.err, x.alu}) begin
      n_fail++;
      $display("FAIL disp_store wb got %b %h exp %b %h", MemErrW, ALUOutW, x.err, x.alu);
    end
`ifdef MEMSTAGE_DISP_PORT_EN
    n_run++;
    if ({disp_valid, disp_data} !== {1'b1, old}) begin
      n_fail++;
      $display("FAIL disp_rbw got %b %h exp 1 %h", disp_valid, disp_data, old);
    end
    issue(mk(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 3'd0));
    tick();
    x = sbq.pop_front();
    n_run++;
    if ({disp_valid, disp_data} !== {1'b1, m_load(2'd2, 1'b0, 32'h10)}) begin
      n_fail++;
      $display("FAIL disp_new got %b %h exp 1 %h", disp_valid, disp_data, 32'h55);
    end
    disp_en = 1'b0;
    issue(mk(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 3'd0));
    tick();
    x = sbq.pop_front();
    n_run++;
    if ({disp_valid, disp_data} !== {1'b0, m_load(2'd2, 1'b0, 32'h10)}) begin
      n_fail++;
      $display("FAIL disp_hold got %b %h exp 0 %h", disp_valid, disp_data, 32'h55);
    end
`else
    n_run++;
    if ({disp_valid, disp_data} !== '0) begin
      n_fail++;
      $display("FAIL disp_off got %b %h exp 0 0 (old %h)", disp_valid, disp_data, old);
    end
    tick();
    n_run++;
    if ({disp_valid, disp_data} !== '0) begin
      n_fail++;
      $display("FAIL disp_off2 got %b %h exp 0 0", disp_valid, disp_data);
    end
    disp_en = 1'b0;
`endif
    idle();
  endtask

  task automatic test_reset_mid_stall();
    exp_t x;
    issue(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h11111111, 3'd0));
    tick();
    x = sbq.pop_front();
    issue(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h0, 3'd3));
    tick();
    x = sbq.pop_front();
    n_run++;
    if (ReadDataW !== x.rd) begin
      n_fail++;
      $display("FAIL rst_pre rdata got %h exp %h", ReadDataW, x.rd);
    end
    stall_w = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({PCSrcW, RegWriteW, MemtoRegW, MemErrW, ReadDataW, ALUOutW, WA3W} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got rw=%b rd=%h alu=%h wa3=%0d exp all 0",
               RegWriteW, ReadDataW, ALUOutW, WA3W);
    end
    stall_w = 1'b0;
    MemWriteM = 1'b1; MemtoRegM = 1'b0; RegWriteM = 1'b0;
    SizeM = 2'd2; ALUResultM = 32'h30; WriteDataM = 32'h22222222;
    tick(); tick();
    n_run++;
    if ({RegWriteW, ALUOutW} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold got %b %h exp 0 0", RegWriteW, ALUOutW);
    end
    idle();
    rst_n = 1'b1;
    tick(); tick(); tick();
    issue(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h0, 3'd4));
    tick();
    x = sbq.pop_front();
    n_run++;
    if ({RegWriteW, WA3W, ReadDataW} !== {x.rw, x.wa3, x.rd}) begin
      n_fail++;
      $display("FAIL ram_kept got %b %0d %h exp %b %0d %h",
               RegWriteW, WA3W, ReadDataW, x.rw, x.wa3, x.rd);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byte_load();
    test_lanes_faults();
    test_back_to_back();
    test_stall_flush();
    test_display();
    test_reset_mid_stall();
    n_run++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d left exp 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
